// File: rtl/clock_rate_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : clock_rate_pkg
// Brief    : shared widths, default divisors and FSM encodings for clock_rate_ctrl
// Revision : 1.0
// -----------------------------------------------------------------------------
package clock_rate_pkg;

    localparam int c_CNT_W = 28;

    localparam logic [27:0] c_DIV0 = 28'd100_000_000;
    localparam logic [27:0] c_DIV1 = 28'd50_000_000;
    localparam logic [27:0] c_DIV2 = 28'd11_111_111;
    localparam logic [27:0] c_DIV3 = 28'd1_000_000;

    typedef logic [1:0] state_t;

    localparam state_t c_STOPPED  = 2'd0;
    localparam state_t c_RUNNING  = 2'd1;
    localparam state_t c_DRAINING = 2'd2;

endpackage : clock_rate_pkg
`default_nettype wire

// File: rtl/clock_div_core.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : clock_div_core
// Brief    : divide counter with registered clock_out/tick; divisor swaps only at wrap
// Revision : 1.0
// -----------------------------------------------------------------------------
module clock_div_core
    import clock_rate_pkg::*;
#(
    parameter int               CNT_W   = c_CNT_W,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(c_DIV0)
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    output logic             wrap,
    output logic             clock_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic             r_clock_out;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = enable && (r_cnt == (r_div - c_ONE));

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_cnt       <= '0;
            r_div       <= DIV_RST;
            r_clock_out <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            if (!enable || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
            // While idle there is no period in flight, so a new divisor can land at once.
            if (load && (w_wrap || !enable)) begin
                r_div <= div_in;
            end
            r_clock_out <= enable && (r_cnt < (r_div >> 1));
            r_tick      <= w_wrap;
        end
    end

    assign wrap      = w_wrap;
    assign clock_out = r_clock_out;
    assign tick      = r_tick;

endmodule : clock_div_core
`default_nettype wire

// File: rtl/clock_rate_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : clock_rate_ctrl
// Brief    : run/stop FSM and req/ack rate-change control for a divided clock
// Revision : 1.0
// -----------------------------------------------------------------------------
module clock_rate_ctrl
    import clock_rate_pkg::*;
#(
    parameter int               CNT_W = c_CNT_W,
    parameter logic [CNT_W-1:0] DIV0  = CNT_W'(c_DIV0),
    parameter logic [CNT_W-1:0] DIV1  = CNT_W'(c_DIV1),
    parameter logic [CNT_W-1:0] DIV2  = CNT_W'(c_DIV2),
    parameter logic [CNT_W-1:0] DIV3  = CNT_W'(c_DIV3)
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] rate_sel,
    input  logic       rate_req,
    output logic       rate_ack,
    output logic       busy,
    output logic [1:0] active_sel,
    output logic       clock_out,
    output logic       tick
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             r_rate_ack;
    logic [1:0]       r_pend_sel;
    logic [1:0]       r_active_sel;
    logic             w_enable;
    logic             w_wrap;
    logic             w_accept;
    logic             w_apply;
    logic [CNT_W-1:0] w_div_new;

    assign w_enable = (r_state != c_STOPPED);
    assign w_accept = rate_req && !r_busy;
    // Pending changes land immediately when idle, otherwise only on a period boundary.
    assign w_apply  = r_busy && (!w_enable || w_wrap);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_STOPPED:  if (run)    w_state_nxt = c_RUNNING;
            c_RUNNING:  if (!run)   w_state_nxt = c_DRAINING;
            c_DRAINING: if (w_wrap) w_state_nxt = run ? c_RUNNING : c_STOPPED;
            default:                w_state_nxt = c_STOPPED;
        endcase
    end

    always_comb begin
        w_div_new = DIV0;
        case (r_pend_sel)
            2'd1:    w_div_new = DIV1;
            2'd2:    w_div_new = DIV2;
            2'd3:    w_div_new = DIV3;
            default: w_div_new = DIV0;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state      <= c_STOPPED;
            r_busy       <= 1'b0;
            r_rate_ack   <= 1'b0;
            r_pend_sel   <= 2'd0;
            r_active_sel <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rate_ack <= w_apply;
            if (w_apply) begin
                r_busy       <= 1'b0;
                r_active_sel <= r_pend_sel;
            end else if (w_accept) begin
                r_busy     <= 1'b1;
                r_pend_sel <= rate_sel;
            end
        end
    end

    clock_div_core #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV0)
    ) u_core (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (w_enable),
        .load      (w_apply),
        .div_in    (w_div_new),
        .wrap      (w_wrap),
        .clock_out (clock_out),
        .tick      (tick)
    );

    assign rate_ack   = r_rate_ack;
    assign busy       = r_busy;
    assign active_sel = r_active_sel;

endmodule : clock_rate_ctrl
`default_nettype wire

// File: tb/tb_clock_rate_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : tb_clock_rate_ctrl
// Brief    : per-cycle vector table with scoreboard queue for clock_rate_ctrl
// Revision : 1.0
// -----------------------------------------------------------------------------
module tb_clock_rate_ctrl;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       run;
    logic [1:0] rate_sel;
    logic       rate_req;
    logic       rate_ack;
    logic       busy;
    logic [1:0] active_sel;
    logic       clock_out;
    logic       tick;

    typedef struct {
        int       idx;
        int       scen;
        bit       rst;
        bit       run;
        bit       req;
        bit [1:0] sel;
        bit       co;
        bit       tk;
        bit       busy;
        bit       ack;
        bit [1:0] asel;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_acks   = 0;

    clock_rate_ctrl #(
        .CNT_W (28),
        .DIV0  (28'd4),
        .DIV1  (28'd6),
        .DIV2  (28'd9),
        .DIV3  (28'd2)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .run        (run),
        .rate_sel   (rate_sel),
        .rate_req   (rate_req),
        .rate_ack   (rate_ack),
        .busy       (busy),
        .active_sel (active_sel),
        .clock_out  (clock_out),
        .tick       (tick)
    );

    always #5 clock_in = ~clock_in;

    function automatic bit [1:0] ch(string s, int i);
        if (s.len() == 0) return 2'd0;
        return 2'(int'(s.getc(i)) - 48);
    endfunction

    // One character per cycle; empty strings mean all zeros.
    function automatic void add_seq(int scen, string rst_s, string run_s, string req_s,
                                    string sel_s, string co_s, string tk_s,
                                    string busy_s, string ack_s, string asel_s);
        vec_t v;
        int   n = co_s.len();
        string all_s[8] = '{rst_s, run_s, req_s, sel_s, tk_s, busy_s, ack_s, asel_s};
        foreach (all_s[k]) begin
            if (all_s[k].len() != 0 && all_s[k].len() != n) begin
                $display("FAIL table scenario %0d: string %0d has length %0d, required %0d",
                         scen, k, all_s[k].len(), n);
                $fatal(1);
            end
        end
        for (int i = 0; i < n; i++) begin
            v.idx  = vecs.size();
            v.scen = scen;
            v.rst  = ch(rst_s, i)[0];
            v.run  = ch(run_s, i)[0];
            v.req  = ch(req_s, i)[0];
            v.sel  = ch(sel_s, i);
            v.co   = ch(co_s, i)[0];
            v.tk   = ch(tk_s, i)[0];
            v.busy = ch(busy_s, i)[0];
            v.ack  = ch(ack_s, i)[0];
            v.asel = ch(asel_s, i);
            vecs.push_back(v);
        end
    endfunction

    initial begin : monitor
        vec_t e;
        forever begin
            @(posedge clock_in);
            #2;
            if (rate_ack === 1'b1) n_acks++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (clock_out === e.co && tick === e.tk && busy === e.busy &&
                    rate_ack === e.ack && active_sel === e.asel) begin
                    n_pass++;
                end else begin
                    $display("FAIL vec%0d scen%0d: got clock_out=%b tick=%b busy=%b rate_ack=%b active_sel=%0d, required %b %b %b %b %0d",
                             e.idx, e.scen, clock_out, tick, busy, rate_ack, active_sel,
                             e.co, e.tk, e.busy, e.ack, e.asel);
                end
            end
        end
    end

    initial begin : driver
        reset    = 1'b1;
        run      = 1'b0;
        rate_req = 1'b0;
        rate_sel = 2'd0;

        // 1: reset, then free-run at DIV0=4 (2 high / 2 low, tick every 4)
        add_seq(1, "100000000000000000000", "011111111111111111111", "", "",
                "001100110011001100110", "000001000100010001000", "", "", "");
        // 2: request rate 2 early in a period, extra request while busy is ignored
        add_seq(2, "", "11111111111111111111111",
                "01100000000000000000000", "02100000000000000000000",
                "01100111100000111100000", "10001000000001000000001",
                "01110000000000000000000", "00001000000000000000000",
                "00002222222222222222222");
        // 3: switch to rate 1, then drop run mid-period and drain to STOPPED
        add_seq(3, "", "11111111110000000", "10000000000000000", "10000000000000000",
                "11110000011100000", "00000000100000100",
                "11111111000000000", "00000000100000000", "22222222111111111");
        // 4: run again, re-raise run during DRAINING (no gap), then stop
        add_seq(4, "", "11111110011111111110000000", "", "",
                "01110001110001110001110000", "00000010000010000010000010",
                "", "", "11111111111111111111111111");
        // 5: stopped change to rate 3, request on a wrap waits a period, reset while busy
        add_seq(5, "0000000000000001000000000", "0001111111111111011111111",
                "1000000001000100000000000", "3000000001000200000000000",
                "0000101010101110001100110", "0000010101010000000001000",
                "1000000001100110000000000", "0100000000010000000000000",
                "1333333333311110000000000");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock_in);
            reset    = vecs[i].rst;
            run      = vecs[i].run;
            rate_req = vecs[i].req;
            rate_sel = vecs[i].sel;
            sb.push_back(vecs[i]);
        end
        @(negedge clock_in);
        reset    = 1'b0;
        run      = 1'b0;
        rate_req = 1'b0;
        repeat (2) @(negedge clock_in);

        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());

        // Acks expected at the rate-2, rate-1, rate-3 and second rate-1 changes only.
        n_checks++;
        if (n_acks == 4) n_pass++;
        else $display("FAIL ack_count: got %0d rate_ack pulses, required 4", n_acks);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_clock_rate_ctrl
`default_nettype wire

// File: doc/clock_rate_ctrl.md
# clock_rate_ctrl

Run/stop and rate-change controller for the board's divided clocks. It owns one divide counter and selects the divisor from four preset rates. Rate changes arrive over a req/ack handshake and take effect only at a period boundary, so the output never shows runt pulses. It replaces the fixed-rate divider instances that drive slow clocks into the display and counter logic; `clock_in` is 100 MHz.

## Interface
- `CNT_W`, 28, counter/divisor width
- `DIV0`, 28'd100_000_000, rate 0 divisor (1 Hz)
- `DIV1`, 28'd50_000_000, rate 1 divisor (2 Hz)
- `DIV2`, 28'd11_111_111, rate 2 divisor (9 Hz)
- `DIV3`, 28'd1_000_000, rate 3 divisor (100 Hz); every DIVn must be ≥ 2
- `clock_in`  in  1  system clock; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `run`  in  1  level; 1 = generate clock, 0 = stop at end of current period
- `rate_sel`  in  2  requested rate index; sampled with `rate_req`
- `rate_req`  in  1  rate-change request; accepted when `busy`=0
- `rate_ack`  out  1  one-cycle pulse when the accepted change takes effect
- `busy`  out  1  a request is accepted but not yet applied
- `active_sel`  out  2  rate index currently in force
- `clock_out`  out  1  divided clock, registered
- `tick`  out  1  one-cycle pulse at each period wrap

## Operation
- Reset values (next edge with `reset`=1): state STOPPED, counter 0, `active_sel`=0, divisor=DIV0, all outputs 0. Reset mid-period aborts the period and drops any pending request without `rate_ack`.
- States:
  - STOPPED: counter held at 0, `clock_out`=0. Goes to RUNNING when `run`=1.
  - RUNNING: counter counts 0..div−1, then wraps to 0. Goes to DRAINING when `run`=0.
  - DRAINING: counts like RUNNING. At the wrap it goes to STOPPED, or returns to RUNNING if `run`=1 (no interruption).
- Output waveform: while RUNNING or DRAINING, `clock_out` is registered from (counter < div>>1). High for floor(div/2) cycles and low for ceil(div/2) cycles. Example: DIV2 gives 5_555_555 high / 5_555_556 low.
- Handshake:
  - A request is accepted on an edge where `rate_req`=1 and `busy`=0; `rate_sel` is latched and `busy`=1 the next cycle.
  - A `rate_req` asserted while `busy`=1 is ignored and produces no ack.
  - A request for the same index as `active_sel` still completes the full handshake.
- Applying a change:
  - In STOPPED, it applies on the next edge: `active_sel` and the divisor update, `rate_ack`=1, `busy`=0.
  - In RUNNING or DRAINING, it applies at the wrap (counter == div−1). The new divisor governs the period starting at counter 0, and `rate_ack` pulses with that wrap while `busy` drops.
- Simultaneous events:
  - A request accepted in the same cycle as a wrap does not apply at that wrap; it waits for the next one.
  - A wrap, a pending apply and a DRAINING→STOPPED transition in the same cycle all happen together.

## Timing
- All outputs are registered; no combinational path from input to output.
- `run` rising while STOPPED: counter reaches 1 on the second edge, and `clock_out` first goes high one cycle after the counter leaves 0 under RUNNING.
- `tick`: high for exactly the one cycle in which counter == 0 following a wrap. Not asserted on the first period after leaving STOPPED.
- Latency from request acceptance to `rate_ack`: 1 cycle when STOPPED; otherwise the remaining cycles of the current period, at most div_old.

## Structure
- Package `clock_rate_pkg`:
  - `CNT_W`
  - default divisor constants DIV0..DIV3
  - state encodings STOPPED=2'd0, RUNNING=2'd1, DRAINING=2'd2
- Sub-module `clock_div_core`: counter, compare and registered `clock_out`/`tick`, with `div_in`, `load` (divisor takes effect at wrap), `enable` and `wrap` outputs. The controller FSM and handshake live in `clock_rate_ctrl`.

## Test plan
Sim parameters: DIV0=4, DIV1=6, DIV2=9, DIV3=2.
- Reset then `run`=1 for 20 cycles → `clock_out` repeats 2 high / 2 low; `tick` every 4 cycles; `active_sel`=0.
- While running at DIV0, request `rate_sel`=2 at counter=1 → `busy` for 3 cycles; `rate_ack` at the wrap; next periods 4 high / 5 low.
- Second `rate_req` while `busy`=1 → ignored; exactly one `rate_ack`; `active_sel` equals the first request.
- Drop `run` mid-period at DIV1 → period completes (3 high / 3 low), then `clock_out` is held 0 and the counter stays 0. Re-raise `run` during DRAINING → no gap between periods.
- While STOPPED, request `rate_sel`=3 → `rate_ack` and `active_sel`=3 after 1 cycle; on `run`=1, `clock_out` toggles every cycle.
- Assert `reset` while `busy`=1 and mid-period → next cycle all outputs 0, `active_sel`=0, and no `rate_ack` ever appears for the aborted request.
